// File: rtl/receptor_serial_pkg.sv
// Shared constants for the serial receiver: FSM state encoding, frame length
// and the default parity sense.
package receptor_serial_pkg;

    typedef enum logic [1:0] {
        INACTIV  = 2'd0,
        DATE     = 2'd1,
        PARITATE = 2'd2,
        STOP     = 2'd3
    } stare_t;

    // start + 8 data + parity + stop
    localparam int LUNGIME_CADRU = 11;

    // 1 = even parity, 0 = odd parity
    localparam int PARITATE_IMPLICITA = 1;

endpackage

// File: rtl/receptor_serial_if.sv
// Consumer-side bundle of the serial receiver: serial line in, held byte,
// status flags and the read acknowledge.
interface receptor_serial_if #(
    parameter int LATIME_DATE = 8
);
    logic                   Date_seriale;
    logic                   Citit;
    logic [LATIME_DATE-1:0] Date;
    logic                   Date_valide;
    logic                   Eroare_paritate;
    logic                   Eroare_cadru;
    logic                   Depasire;
    logic                   Ocupat;

    modport master (
        output Date_seriale, Citit,
        input  Date, Date_valide, Eroare_paritate, Eroare_cadru, Depasire, Ocupat
    );

    modport slave (
        input  Date_seriale, Citit,
        output Date, Date_valide, Eroare_paritate, Eroare_cadru, Depasire, Ocupat
    );
endinterface

// File: rtl/registru_deplasare_rx.sv
// MSB-first receive shift register with a running XOR of the shifted-in bits.
// Cleared on the start bit; holds its value outside of shifting.
module registru_deplasare_rx #(
    parameter int LATIME_DATE = 8
) (
    input  logic                   clk,
    input  logic                   sterge,
    input  logic                   deplaseaza,
    input  logic                   bit_in,
    output logic [LATIME_DATE-1:0] date,
    output logic                   paritate
);

    always_ff @(posedge clk) begin
        if (sterge) begin
            date     <= '0;
            paritate <= 1'b0;
        end else if (deplaseaza) begin
            date     <= {date[LATIME_DATE-2:0], bit_in};
            paritate <= paritate ^ bit_in;
        end
    end

endmodule

// File: rtl/receptor_serial.sv
// Serial frame receiver: start, 8 data bits MSB first, parity, stop.
// Delivers each byte into a hold register with a read handshake and error flags.
module receptor_serial
    import receptor_serial_pkg::*;
#(
    parameter int PARITATE_PARA = PARITATE_IMPLICITA,
    parameter int LATIME_DATE   = 8
) (
    input  logic                   Ceas,
    input  logic                   Reset,
    input  logic                   Date_seriale,
    input  logic                   Citit,
    output logic [LATIME_DATE-1:0] Date,
    output logic                   Date_valide,
    output logic                   Eroare_paritate,
    output logic                   Eroare_cadru,
    output logic                   Depasire,
    output logic                   Ocupat
);

    localparam int               CNT_W = $clog2(LATIME_DATE);
    localparam logic [CNT_W-1:0] ULTIM = CNT_W'(LATIME_DATE - 1);

    stare_t                 stare, stare_urm;
    logic [CNT_W-1:0]       cnt, cnt_urm;
    logic                   sterge, deplaseaza, esantion_par, incarca;
    logic [LATIME_DATE-1:0] sr_date;
    logic                   sr_par;
    logic                   eroare_par_pend;

    function automatic logic paritate_asteptata(input logic acc);
        return (PARITATE_PARA != 0) ? acc : ~acc;
    endfunction

    registru_deplasare_rx #(.LATIME_DATE(LATIME_DATE)) u_sr (
        .clk        (Ceas),
        .sterge     (sterge),
        .deplaseaza (deplaseaza),
        .bit_in     (Date_seriale),
        .date       (sr_date),
        .paritate   (sr_par)
    );

    always_ff @(posedge Ceas or posedge Reset) begin
        if (Reset) begin
            stare <= INACTIV;
            cnt   <= '0;
        end else begin
            stare <= stare_urm;
            cnt   <= cnt_urm;
        end
    end

    always_comb begin
        stare_urm    = stare;
        cnt_urm      = cnt;
        sterge       = 1'b0;
        deplaseaza   = 1'b0;
        esantion_par = 1'b0;
        incarca      = 1'b0;
        case (stare)
            INACTIV: begin
                if (!Date_seriale) begin
                    stare_urm = DATE;
                    cnt_urm   = '0;
                    sterge    = 1'b1;
                end
            end
            DATE: begin
                deplaseaza = 1'b1;
                cnt_urm    = cnt + 1'b1;
                if (cnt == ULTIM) stare_urm = PARITATE;
            end
            PARITATE: begin
                esantion_par = 1'b1;
                stare_urm    = STOP;
            end
            STOP: begin
                incarca   = 1'b1;
                stare_urm = INACTIV;
            end
            default: stare_urm = INACTIV;
        endcase
    end

    // Parity verdict is taken in PARITATE and published together with the byte.
    always_ff @(posedge Ceas) begin
        if (esantion_par) eroare_par_pend <= (Date_seriale != paritate_asteptata(sr_par));
    end

    // Hold register: a completing frame wins over a coincident read.
    always_ff @(posedge Ceas or posedge Reset) begin
        if (Reset) begin
            Date            <= '0;
            Date_valide     <= 1'b0;
            Eroare_paritate <= 1'b0;
            Eroare_cadru    <= 1'b0;
            Depasire        <= 1'b0;
        end else if (incarca) begin
            Date            <= sr_date;
            Date_valide     <= 1'b1;
            Eroare_paritate <= eroare_par_pend;
            Eroare_cadru    <= ~Date_seriale;
            if (Date_valide && !Citit) Depasire <= 1'b1;
        end else if (Date_valide && Citit) begin
            Date_valide <= 1'b0;
        end
    end

    assign Ocupat = (stare != INACTIV);

endmodule

// File: tb/tb_receptor_serial.sv
// Bench for receptor_serial: directed frames plus random traffic, checked
// against a frame-level model of the held byte and flags.
module tb_receptor_serial;
    import receptor_serial_pkg::*;

    logic Ceas = 1'b0;
    logic Reset;

    receptor_serial_if bus ();

    receptor_serial dut (
        .Ceas            (Ceas),
        .Reset           (Reset),
        .Date_seriale    (bus.Date_seriale),
        .Citit           (bus.Citit),
        .Date            (bus.Date),
        .Date_valide     (bus.Date_valide),
        .Eroare_paritate (bus.Eroare_paritate),
        .Eroare_cadru    (bus.Eroare_cadru),
        .Depasire        (bus.Depasire),
        .Ocupat          (bus.Ocupat)
    );

    always #5 Ceas = ~Ceas;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_date;
    logic       exp_valid, exp_pe, exp_fe, exp_dep;
    logic       vld_pre;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".date"},   bus.Date,            exp_date);
        chk({tag, ".valid"},  bus.Date_valide,     exp_valid);
        chk({tag, ".perr"},   bus.Eroare_paritate, exp_pe);
        chk({tag, ".ferr"},   bus.Eroare_cadru,    exp_fe);
        chk({tag, ".ovr"},    bus.Depasire,        exp_dep);
    endtask

    task automatic model_reset();
        exp_date  = 8'h00;
        exp_valid = 1'b0;
        exp_pe    = 1'b0;
        exp_fe    = 1'b0;
        exp_dep   = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit bad, input bit stopb, input bit ack);
        logic bits [LUNGIME_CADRU];
        logic par;
        par = (($countones(b) % 2) == 1) ^ bad;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[7-k];
        bits[9]  = par;
        bits[10] = stopb;
        for (int i = 0; i < LUNGIME_CADRU; i++) begin
            if (i == 5) chk("busy_mid", bus.Ocupat, 8'd1);
            if (i == 10) vld_pre = bus.Date_valide;
            bus.Date_seriale = bits[i];
            bus.Citit        = ack && (i == 10);
            @(negedge Ceas);
        end
        bus.Citit        = 1'b0;
        bus.Date_seriale = 1'b1;
        if (exp_valid && !ack) exp_dep = 1'b1;
        exp_valid = 1'b1;
        exp_date  = b;
        exp_pe    = bad;
        exp_fe    = !stopb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Date_seriale = 1'b1;
            bus.Citit        = 1'b0;
            @(negedge Ceas);
        end
    endtask

    task automatic rd();
        bus.Date_seriale = 1'b1;
        bus.Citit        = 1'b1;
        @(negedge Ceas);
        bus.Citit = 1'b0;
        exp_valid = 1'b0;
    endtask

    initial begin
        Reset            = 1'b1;
        bus.Date_seriale = 1'b1;
        bus.Citit        = 1'b0;
        model_reset();
        @(negedge Ceas);
        @(negedge Ceas);
        check_all("reset");
        chk("reset.busy", bus.Ocupat, 8'd0);
        Reset = 1'b0;
        idle(2);

        // Nominal A5, even parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("a5.latency", vld_pre, 8'd0);
        check_all("a5");
        rd();
        chk("a5.read", bus.Date_valide, 8'd0);
        idle(1);

        // Parity error
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        check_all("f0");
        rd();
        idle(1);

        // Frame error, FSM idle right after
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        check_all("01");
        chk("01.idle", bus.Ocupat, 8'd0);
        idle(1);

        // Back-to-back, no read in between
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        check_all("b2b");

        // Reset after data bit 4, line held low during reset
        bus.Date_seriale = 1'b0;
        @(negedge Ceas);
        for (int i = 0; i < 5; i++) begin
            bus.Date_seriale = i[0];
            @(negedge Ceas);
        end
        Reset            = 1'b1;
        bus.Date_seriale = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("rst_mid.busy", bus.Ocupat, 8'd0);
        @(negedge Ceas);
        Reset = 1'b0;
        idle(2);
        chk("rst_mid.idle", bus.Ocupat, 8'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_all("5a");

        // Handshake one cycle after valid
        rd();
        check_all("5a.rd");

        // Read ignored while nothing is held
        rd();
        check_all("idle_rd");

        // Completion coinciding with read: new byte wins, no overrun
        send_frame(8'h96, 1'b0, 1'b1, 1'b0);
        send_frame(8'h69, 1'b0, 1'b1, 1'b1);
        check_all("coinc");
        rd();
        idle(1);

        // Random traffic
        for (int r = 0; r < 24; r++) begin
            logic [7:0] b;
            bit bad, stopb, ack;
            b     = 8'($urandom);
            bad   = ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 7) != 0);
            ack   = ($urandom_range(0, 5) == 0);
            send_frame(b, bad, stopb, ack);
            check_all("rnd");
            if ($urandom_range(0, 1) == 1) begin
                rd();
                chk("rnd.rd", bus.Date_valide, 8'd0);
            end
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receptor_serial.md
RECEPTOR_SERIAL -- requirements
Module: receptor_serial

Interface
REQ-001 SHALL have parameter PARITATE_PARA, default 1, meaning 1 = even parity and 0 = odd parity expected.
REQ-002 SHALL have parameter LATIME_DATE, default 8, meaning payload width in bits; only the value 8 is required to work.
REQ-003 SHALL have port Ceas, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port Date_seriale, input, 1, serial line from the upstream transmitter, one bit per Ceas cycle, idle high.
REQ-006 SHALL have port Citit, input, 1, consumer acknowledge for the held byte.
REQ-007 SHALL have port Date, output, 8, last received byte.
REQ-008 SHALL have port Date_valide, output, 1, Date holds an unread byte.
REQ-009 SHALL have port Eroare_paritate, output, 1, parity mismatch on the byte in Date.
REQ-010 SHALL have port Eroare_cadru, output, 1, stop bit of the last frame was 0.
REQ-011 SHALL have port Depasire, output, 1, sticky overrun flag.
REQ-012 SHALL have port Ocupat, output, 1, a frame is being received.

Function
REQ-013 SHALL use this frame: start bit 0, then 8 data bits MSB first (bit 7 to bit 0), then 1 parity bit, then stop bit 1; 11 cycles in total.
REQ-014 SHALL implement a state machine with states INACTIV, DATE, PARITATE and STOP.
REQ-015 SHALL move from INACTIV to DATE when Date_seriale = 0 is sampled in INACTIV; that cycle is the start bit.
REQ-016 SHALL shift one data bit per cycle while in DATE, using a 3-bit counter; it SHALL move to PARITATE after the 8th bit, when the counter wraps from 7 to 0.
REQ-017 SHALL, in PARITATE, compare the sampled bit with the XOR of the 8 data bits (inverted when PARITATE_PARA = 0), then move to STOP.
REQ-018 SHALL, in STOP, load the shift register into Date and set Date_valide = 1 in the next cycle; Eroare_paritate and Eroare_cadru SHALL be updated in the same cycle; the FSM SHALL then return to INACTIV.
REQ-019 SHALL have a latency of 11 cycles from the start-bit sample to Date_valide rising.
REQ-020 SHALL still deliver the byte when the stop bit is 0, with Eroare_cadru = 1.
REQ-021 SHALL accept a start bit sampled in the cycle directly after STOP, so back-to-back frames with no idle gap are received.
REQ-022 SHALL clear Date_valide on the cycle after Citit is sampled high while Date_valide = 1; Date, Eroare_paritate and Eroare_cadru SHALL be held until the next load.
REQ-023 SHALL, when a new frame completes while Date_valide = 1 and Citit = 0, overwrite Date, keep Date_valide = 1 and set Depasire = 1.
REQ-024 SHALL, when completion and Citit coincide, give priority to the new byte: Date_valide = 1 and Depasire unchanged.
REQ-025 SHALL clear Depasire only by Reset.
REQ-026 SHALL ignore Citit while Date_valide = 0.
REQ-027 SHALL drive Ocupat = 1 in states DATE, PARITATE and STOP, and 0 otherwise.

Reset
REQ-028 SHALL, on Reset high at any time including mid-frame, immediately force: state INACTIV, counter 0, Date = 8'h00, Date_valide = 0, Eroare_paritate = 0, Eroare_cadru = 0, Depasire = 0, Ocupat = 0.
REQ-029 SHALL discard any partially received frame on reset, and SHALL NOT accept a start bit until the first rising edge after Reset is deasserted.

Structure
REQ-030 SHALL place the state encoding (INACTIV, DATE, PARITATE, STOP), LUNGIME_CADRU = 11 and the default parity constant in a shared package.
REQ-031 SHALL implement the data shift register and parity accumulator in one sub-module, registru_deplasare_rx, instantiated once; the FSM, counter and hold register SHALL remain in receptor_serial.

Verification
REQ-032 SHALL cover nominal reception: frame 0,1010_0101,0,1 with even parity -> Date = 8'hA5 and Date_valide = 1 at cycle 11, no error flags set.
REQ-033 SHALL cover parity error: frame 0,1111_0000,1,1 with even parity -> Date = 8'hF0, Eroare_paritate = 1.
REQ-034 SHALL cover frame error: frame 0,0000_0001,1,0 -> Date = 8'h01, Eroare_cadru = 1, FSM in INACTIV at the next cycle.
REQ-035 SHALL cover back-to-back frames with no Citit: 8'h3C then 8'hC3 -> Date = 8'hC3, Depasire = 1, Date_valide = 1.
REQ-036 SHALL cover reset mid-frame: Reset pulsed after data bit 4, then a full frame of 8'h5A -> only 8'h5A delivered and all flags 0.
REQ-037 SHALL cover handshake: Citit pulsed 1 cycle after Date_valide -> Date_valide = 0 next cycle and Date still 8'h5A.
